// File: rtl/gelato_wb_arbiter.sv
// gelato_wb_arbiter: N-channel writeback arbiter with a single registered output slot.
// Round-robin or fixed-priority-with-anti-starvation selection, chosen by ARB_MODE.
module gelato_wb_arbiter #(
    parameter int NUM_CH    = 3,
    parameter int PAYLOAD_W = 64,
    parameter int ARB_MODE  = 0,
    parameter int MAX_WAIT  = 15,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic [NUM_CH*PAYLOAD_W-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PAYLOAD_W-1:0]        out_data,
    output logic [CH_W-1:0]             out_ch
);
    logic            load_en;
    logic            grant;
    logic            st_found;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] rr_win;
    logic [CH_W-1:0] fp_win;
    logic [CH_W-1:0] st_win;
    logic [CH_W-1:0] win;
    logic [7:0]      wait_cnt [NUM_CH];

    // Loops run from the far end so the nearest match overwrites earlier ones.
    always_comb begin
        rr_win   = '0;
        fp_win   = '0;
        st_win   = '0;
        st_found = 1'b0;
        for (int k = NUM_CH; k >= 1; k--)
            if (in_valid[(int'(last_grant) + k) % NUM_CH])
                rr_win = CH_W'((int'(last_grant) + k) % NUM_CH);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_valid[i])
                fp_win = CH_W'(i);
            if (in_valid[i] && wait_cnt[i] == 8'(MAX_WAIT)) begin
                st_win   = CH_W'(i);
                st_found = 1'b1;
            end
        end
        win      = (ARB_MODE == 1) ? (st_found ? st_win : fp_win) : rr_win;
        load_en  = !out_valid || out_ready;
        grant    = !rst && load_en && (|in_valid);
        in_ready = grant ? (NUM_CH'(1) << win) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (grant) begin
            out_valid  <= 1'b1;
            out_data   <= in_data[win*PAYLOAD_W +: PAYLOAD_W];
            out_ch     <= win;
            last_grant <= win;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Waiting under output backpressure is not starvation, so counters only move with load_en.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst)
                wait_cnt[i] <= '0;
            else if (load_en && in_ready[i])
                wait_cnt[i] <= '0;
            else if (load_en && in_valid[i] && wait_cnt[i] != 8'(MAX_WAIT))
                wait_cnt[i] <= wait_cnt[i] + 8'd1;
        end
    end
endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// tb_gelato_wb_arbiter: directed checks of three arbiter configurations
// (3-ch round-robin, 5-ch round-robin, 3-ch anti-starvation) plus a random scoreboard run.
module tb_gelato_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0;
    int          fails = 0;

    logic [2:0]  v0 = '0, r0;
    logic [47:0] dt0 = {16'hC002, 16'hB001, 16'hA000};
    logic        ov0, or0 = 1'b0;
    logic [15:0] od0;
    logic [1:0]  oc0;

    logic [4:0]  v1 = '0, r1;
    logic [79:0] dt1 = {16'hD004, 16'hD003, 16'hD002, 16'hD001, 16'hD000};
    logic        ov1, or1 = 1'b0;
    logic [15:0] od1;
    logic [2:0]  oc1;

    logic [2:0]  v2 = '0, r2;
    logic [47:0] dt2 = {16'hC002, 16'hB001, 16'hA000};
    logic        ov2, or2 = 1'b0;
    logic [15:0] od2;
    logic [1:0]  oc2;

    always #5 clk = ~clk;

    gelato_wb_arbiter #(.NUM_CH(3), .PAYLOAD_W(16), .ARB_MODE(0)) d0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(dt0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ch(oc0));
    gelato_wb_arbiter #(.NUM_CH(5), .PAYLOAD_W(16), .ARB_MODE(0)) d1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(dt1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ch(oc1));
    gelato_wb_arbiter #(.NUM_CH(3), .PAYLOAD_W(16), .ARB_MODE(1), .MAX_WAIT(3)) d2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(dt2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ch(oc2));

    function automatic logic [15:0] pay(input int c);
        return 16'hA000 + 16'(c) * 16'h1001;
    endfunction

    // Every task starts and ends just after a falling edge.
    task automatic apply_reset();
        rst = 1'b1;
        v0 = '0; v1 = '0; v2 = '0;
        or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;
        dt0 = {16'hC002, 16'hB001, 16'hA000};
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; v0 = 3'b111; or0 = 1'b1;
        #1;
        tests++; if (r0 !== 3'b000) begin fails++; $display("FAIL reset_in_ready got %b exp 000", r0); end
        @(posedge clk); #1;
        tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", ov0); end
        tests++; if (od0 !== 16'h0) begin fails++; $display("FAIL reset_out_data got %h exp 0000", od0); end
        tests++; if (oc0 !== 2'd0) begin fails++; $display("FAIL reset_out_ch got %0d exp 0", oc0); end
        @(negedge clk);
        rst = 1'b0; v0 = '0;
    endtask

    task automatic test_round_robin();
        v0 = 3'b111; or0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++; if (r0 !== 3'(1 << (i % 3))) begin fails++; $display("FAIL rr_ready[%0d] got %b exp %b", i, r0, 3'(1 << (i % 3))); end
            @(posedge clk); #1;
            tests++; if (ov0 !== 1'b1 || oc0 !== 2'(i % 3) || od0 !== pay(i % 3)) begin
                fails++; $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", i, ov0, oc0, od0, i % 3, pay(i % 3));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drain();
        v0 = '0; or0 = 1'b1;
        #1;
        tests++; if (r0 !== 3'b000) begin fails++; $display("FAIL idle_ready got %b exp 000", r0); end
        @(posedge clk); #1;
        tests++; if (ov0 !== 1'b0 || oc0 !== 2'd2 || od0 !== pay(2)) begin
            fails++; $display("FAIL drain got v=%b ch=%0d d=%h exp v=0 ch=2 d=%h", ov0, oc0, od0, pay(2));
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        apply_reset();
        v0 = 3'b010; or0 = 1'b0;
        @(negedge clk);
        v0 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (r0 !== 3'b000) begin fails++; $display("FAIL bp_ready[%0d] got %b exp 000", i, r0); end
            @(posedge clk); #1;
            tests++; if (ov0 !== 1'b1 || oc0 !== 2'd1 || od0 !== pay(1)) begin
                fails++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h exp v=1 ch=1 d=%h", i, ov0, oc0, od0, pay(1));
            end
            @(negedge clk);
        end
        or0 = 1'b1;
        #1;
        tests++; if (r0 !== 3'b100) begin fails++; $display("FAIL bp_next_ready got %b exp 100", r0); end
        @(posedge clk); #1;
        tests++; if (oc0 !== 2'd2 || od0 !== pay(2)) begin fails++; $display("FAIL bp_next_ch got %0d exp 2", oc0); end
        @(negedge clk);
        v0 = 3'b001;
        #1;
        tests++; if (r0 !== 3'b001) begin fails++; $display("FAIL bp_then_ready got %b exp 001", r0); end
        @(posedge clk); #1;
        tests++; if (oc0 !== 2'd0 || ov0 !== 1'b1) begin fails++; $display("FAIL bp_then_ch got %0d exp 0", oc0); end
        @(negedge clk);
        v0 = '0;
    endtask

    task automatic test_wrap();
        apply_reset();
        v1 = 5'b01000; or1 = 1'b1;
        @(posedge clk); #1;
        tests++; if (oc1 !== 3'd3) begin fails++; $display("FAIL wrap_setup got %0d exp 3", oc1); end
        @(negedge clk);
        v1 = 5'b10001;
        #1;
        tests++; if (r1 !== 5'b10000) begin fails++; $display("FAIL wrap_ready4 got %b exp 10000", r1); end
        @(posedge clk); #1;
        tests++; if (oc1 !== 3'd4 || od1 !== 16'hD004) begin fails++; $display("FAIL wrap_ch4 got ch=%0d d=%h exp ch=4 d=d004", oc1, od1); end
        @(negedge clk);
        v1 = 5'b00001;
        #1;
        tests++; if (r1 !== 5'b00001) begin fails++; $display("FAIL wrap_ready0 got %b exp 00001", r1); end
        @(posedge clk); #1;
        tests++; if (oc1 !== 3'd0 || od1 !== 16'hD000) begin fails++; $display("FAIL wrap_ch0 got ch=%0d d=%h exp ch=0 d=d000", oc1, od1); end
        @(negedge clk);
        v1 = '0;
    endtask

    task automatic test_starvation();
        logic [1:0] exp_seq [8] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2};
        apply_reset();
        v2 = 3'b101; or2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            tests++; if (ov2 !== 1'b1 || oc2 !== exp_seq[i]) begin
                fails++; $display("FAIL starve[%0d] got v=%b ch=%0d exp v=1 ch=%0d", i, ov2, oc2, exp_seq[i]);
            end
            @(negedge clk);
        end
        v2 = '0;
    endtask

    task automatic test_wait_freeze();
        logic [1:0] exp_seq [3] = '{2'd0, 2'd0, 2'd2};
        apply_reset();
        v2 = 3'b101; or2 = 1'b0;
        @(posedge clk); #1;
        tests++; if (oc2 !== 2'd0 || ov2 !== 1'b1) begin fails++; $display("FAIL freeze_first got ch=%0d exp 0", oc2); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (r2 !== 3'b000) begin fails++; $display("FAIL freeze_ready[%0d] got %b exp 000", i, r2); end
            @(negedge clk);
        end
        or2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++; if (oc2 !== exp_seq[i]) begin fails++; $display("FAIL freeze_seq[%0d] got ch=%0d exp %0d", i, oc2, exp_seq[i]); end
            @(negedge clk);
        end
        v2 = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        v0 = 3'b001; or0 = 1'b0;
        @(posedge clk); #1;
        tests++; if (ov0 !== 1'b1) begin fails++; $display("FAIL mid_loaded got %b exp 1", ov0); end
        @(negedge clk);
        rst = 1'b1; v0 = 3'b110;
        #1;
        tests++; if (r0 !== 3'b000) begin fails++; $display("FAIL mid_rst_ready got %b exp 000", r0); end
        @(posedge clk); #1;
        tests++; if (ov0 !== 1'b0 || oc0 !== 2'd0 || od0 !== 16'h0) begin
            fails++; $display("FAIL mid_rst_out got v=%b ch=%0d d=%h exp v=0 ch=0 d=0000", ov0, oc0, od0);
        end
        @(negedge clk);
        rst = 1'b0; or0 = 1'b1;
        #1;
        tests++; if (r0 !== 3'b010) begin fails++; $display("FAIL mid_after_ready got %b exp 010", r0); end
        @(posedge clk); #1;
        tests++; if (ov0 !== 1'b1 || oc0 !== 2'd1 || od0 !== pay(1)) begin
            fails++; $display("FAIL mid_after_out got v=%b ch=%0d d=%h exp v=1 ch=1 d=%h", ov0, oc0, od0, pay(1));
        end
        @(negedge clk);
        v0 = '0;
    endtask

    task automatic test_random();
        logic [17:0] q [$];
        logic [17:0] e;
        logic [2:0]  acc = '0;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            v0 = v0 & ~acc;
            for (int c = 0; c < 3; c++)
                if (!v0[c] && $urandom_range(0, 1) == 1) begin
                    v0[c] = 1'b1;
                    dt0[c*16 +: 16] = 16'($urandom);
                end
            or0 = ($urandom_range(0, 3) != 0);
            #1;
            tests++; if ((r0 & (r0 - 3'd1)) != 3'b000 || (r0 & ~v0) != 3'b000) begin
                fails++; $display("FAIL rand_ready[%0d] got %b valid %b exp onehot within valid", n, r0, v0);
            end
            if (ov0 && or0) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_extra[%0d] got ch=%0d d=%h exp none", n, oc0, od0);
                end else begin
                    e = q.pop_front();
                    if ({oc0, od0} !== e) begin
                        fails++; $display("FAIL rand_out[%0d] got ch=%0d d=%h exp ch=%0d d=%h", n, oc0, od0, e[17:16], e[15:0]);
                    end
                end
            end
            acc = r0 & v0;
            for (int c = 0; c < 3; c++)
                if (acc[c]) q.push_back({2'(c), dt0[c*16 +: 16]});
            @(negedge clk);
        end
        v0 = '0; or0 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            if (ov0) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_drain_extra got ch=%0d d=%h exp none", oc0, od0);
                end else begin
                    e = q.pop_front();
                    if ({oc0, od0} !== e) begin
                        fails++; $display("FAIL rand_drain got ch=%0d d=%h exp ch=%0d d=%h", oc0, od0, e[17:16], e[15:0]);
                    end
                end
            end
            @(negedge clk);
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rand_lost got %0d pending exp 0", q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_drain();
        test_backpressure();
        test_wrap();
        test_starvation();
        test_wait_freeze();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gelato_wb_arbiter.md
GELATO_WB_ARBITER -- requirements
Module: gelato_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning the number of writeback source channels (range 2..16).
REQ-002 SHALL have parameter PAYLOAD_W, default 64, meaning the writeback payload width in bits (warp id, register index and data).
REQ-003 SHALL have parameter ARB_MODE, default 0, meaning the arbitration policy: 0 = round-robin, 1 = fixed priority with the lowest index winning, plus anti-starvation.
REQ-004 SHALL have parameter MAX_WAIT, default 15, meaning the wait-cycle threshold for anti-starvation escalation (ARB_MODE=1 only; range 1..255).
REQ-005 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock, synchronous and active-high.
REQ-007 SHALL have port in_valid  input  NUM_CH  per-channel writeback request.
REQ-008 SHALL have port in_ready  output  NUM_CH  per-channel accept; at most one bit high per cycle.
REQ-009 SHALL have port in_data  input  NUM_CH*PAYLOAD_W  channel payloads, with channel i at bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-010 SHALL have port out_valid  output  1  registered writeback valid toward the register file.
REQ-011 SHALL have port out_ready  input  1  register-file accept.
REQ-012 SHALL have port out_data  output  PAYLOAD_W  registered payload.
REQ-013 SHALL have port out_ch  output  max(1,$clog2(NUM_CH))  index of the source channel of out_data.

Function
REQ-014 SHALL hold a single-entry output register; a transfer on either side occurs only when valid and ready are both high in the same cycle.
REQ-015 SHALL assert load_en = !out_valid || out_ready; when load_en is 0, every in_ready bit SHALL be 0.
REQ-016 SHALL select the winner combinationally from in_valid; in_ready[w]=1 only when load_en is 1 and in_valid[w] is 1, where w is the winner.
REQ-017 SHALL, on an input transfer, load out_data/out_ch from the winner and set out_valid=1 on the next edge (1-cycle latency); sustained throughput SHALL be 1 transfer per cycle.
REQ-018 SHALL, on an output transfer with no input transfer in the same cycle, clear out_valid on the next edge; out_data/out_ch SHALL hold their last value.
REQ-019 SHALL, when output drain and input load coincide, replace the entry with no bubble.
REQ-020 SHALL keep out_data/out_ch stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, in ARB_MODE=0, search starting at last_grant+1 and wrap from NUM_CH-1 to 0 (explicit modulo NUM_CH, including when NUM_CH is not a power of 2); the first valid channel wins.
REQ-022 SHALL update last_grant only on an input transfer; if no input transfer occurs, last_grant SHALL be unchanged.
REQ-023 SHALL, in ARB_MODE=1, keep a wait counter per channel that increments (saturating at MAX_WAIT) in any cycle where in_valid[i]=1 and in_ready[i]=0, and clears to 0 on channel i's transfer.
REQ-024 SHALL, in ARB_MODE=1, have the lowest-index channel whose counter equals MAX_WAIT win; if none has reached it, the lowest-index valid channel wins.
REQ-025 SHALL keep wait counters frozen while load_en=0 (backpressure does not count as starvation).
REQ-026 SHALL, with no in_valid bits set, keep all in_ready bits at 0 and leave state unchanged apart from the output drain.
REQ-027 SHALL require a source to hold in_valid and in_data stable until accepted; dropping in_valid without a transfer is a protocol error and SHALL NOT corrupt arbiter state.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set out_valid=0, out_data=0, out_ch=0, last_grant=NUM_CH-1 (so channel 0 is served first) and all wait counters to 0.
REQ-029 SHALL hold in_ready at all zeros during any cycle with rst=1.
REQ-030 SHALL, on reset mid-operation, discard a held entry without an output handshake; the next grant after reset SHALL follow REQ-028.

Verification
REQ-031 SHALL cover: NUM_CH=3, ARB_MODE=0, in_valid=3'b111 held, out_ready=1 -> out_ch sequence 0,1,2,0,1,2 on consecutive cycles with out_valid continuously 1.
REQ-032 SHALL cover: entry from channel 1 held and out_ready=0 for 4 cycles with in_valid=3'b101 -> in_ready=0 throughout, out_data unchanged; after out_ready=1, the next grant is channel 2 (then 0).
REQ-033 SHALL cover: NUM_CH=5, ARB_MODE=0, only channels 4 and 0 valid, last_grant=3 -> grants are 4, then 0 (wrap checked).
REQ-034 SHALL cover: ARB_MODE=1, MAX_WAIT=3, channels 0 and 2 valid continuously with out_ready=1 -> channel 0 wins 3 times, then channel 2 wins once, then channel 0 resumes.
REQ-035 SHALL cover: rst=1 asserted while out_valid=1 -> next cycle out_valid=0, out_ch=0; with in_valid=3'b110 after release, first grant is channel 1.
REQ-036 SHALL cover: random valid/ready stimulus with a scoreboard -> every accepted payload appears exactly once, in acceptance order, with the correct out_ch.
